// File: rtl/otter_ctrl_pkg.sv
// Shared types for the OTTER pipelined control unit.
// Opcodes, branch func3 codes, the per-stage control word and selects.
package otter_ctrl_pkg;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_func3_t;

    typedef struct packed {
        logic [3:0] alu_func;
        logic       mem_read;
        logic       mem_write;
        logic       mem_sign;
        logic [1:0] mem_size;
        logic       reg_wr_en;
        logic       csr_write;
        logic [1:0] rf_wr_sel;
        logic [4:0] rd;
        logic       valid;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    localparam logic [2:0] PC_PLUS4  = 3'd0;
    localparam logic [2:0] PC_JAL    = 3'd1;
    localparam logic [2:0] PC_BRANCH = 3'd2;
    localparam logic [2:0] PC_JALR   = 3'd3;
    localparam logic [2:0] PC_MTVEC  = 3'd5;

    function automatic logic br_cond(
        input logic [2:0] f3,
        input logic       eq,
        input logic       lt,
        input logic       ltu
    );
        logic r;
        r = 1'b0;
        case (br_func3_t'(f3))
            BR_EQ:   r = eq;
            BR_NE:   r = ~eq;
            BR_LT:   r = lt;
            BR_GE:   r = ~lt;
            BR_LTU:  r = ltu;
            BR_GEU:  r = ~ltu;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/otter_ctrl_decode.sv
// Combinational decode of the decode-stage IR into a control word,
// register-usage bits, operand selects and transfer-type flags.
module otter_ctrl_decode
    import otter_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output ctrl_t       ctrl,
    output logic        use_rs1,
    output logic        use_rs2,
    output logic        alu_srca,
    output logic [1:0]  alu_srcb,
    output logic        is_jal,
    output logic        is_jalr,
    output logic        is_branch,
    output logic        is_trap
);

    opcode_t    opc;
    logic [2:0] f3;
    logic       f7b5;
    logic       unused_ir;

    assign opc       = opcode_t'(ir[6:0]);
    assign f3        = ir[14:12];
    assign f7b5      = ir[30];
    assign unused_ir = ^{ir[31], ir[29:15]};

    always_comb begin
        ctrl      = CTRL_BUBBLE;
        ctrl.rd   = ir[11:7];
        use_rs1   = 1'b1;
        use_rs2   = 1'b0;
        alu_srca  = 1'b0;
        alu_srcb  = 2'd0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_branch = 1'b0;
        is_trap   = 1'b0;
        unique case (1'b1)
            opc == OPC_LUI: begin
                ctrl.valid     = 1'b1;
                ctrl.reg_wr_en = 1'b1;
                ctrl.rf_wr_sel = 2'd3;
                ctrl.alu_func  = 4'd9;
                alu_srca       = 1'b1;
                use_rs1        = 1'b0;
            end
            opc == OPC_AUIPC: begin
                ctrl.valid     = 1'b1;
                ctrl.reg_wr_en = 1'b1;
                ctrl.rf_wr_sel = 2'd3;
                alu_srca       = 1'b1;
                alu_srcb       = 2'd3;
                use_rs1        = 1'b0;
            end
            opc == OPC_JAL: begin
                ctrl.valid     = 1'b1;
                ctrl.reg_wr_en = 1'b1;
                ctrl.alu_func  = 4'd9;
                use_rs1        = 1'b0;
                is_jal         = 1'b1;
            end
            opc == OPC_JALR: begin
                ctrl.valid     = 1'b1;
                ctrl.reg_wr_en = 1'b1;
                ctrl.alu_func  = 4'd9;
                alu_srcb       = 2'd1;
                is_jalr        = 1'b1;
            end
            opc == OPC_BRANCH: begin
                ctrl.valid = 1'b1;
                use_rs2    = 1'b1;
                is_branch  = 1'b1;
            end
            opc == OPC_LOAD: begin
                ctrl.valid     = 1'b1;
                ctrl.reg_wr_en = 1'b1;
                ctrl.rf_wr_sel = 2'd2;
                ctrl.mem_read  = 1'b1;
                ctrl.mem_sign  = f3[2];
                ctrl.mem_size  = f3[1:0];
                alu_srcb       = 2'd1;
            end
            opc == OPC_STORE: begin
                ctrl.valid     = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.mem_sign  = f3[2];
                ctrl.mem_size  = f3[1:0];
                alu_srcb       = 2'd2;
                use_rs2        = 1'b1;
            end
            opc == OPC_OP_IMM: begin
                ctrl.valid     = 1'b1;
                ctrl.reg_wr_en = 1'b1;
                ctrl.rf_wr_sel = 2'd3;
                ctrl.alu_func  = {(f3 == 3'b101) & f7b5, f3};
                alu_srcb       = 2'd1;
            end
            opc == OPC_OP: begin
                ctrl.valid     = 1'b1;
                ctrl.reg_wr_en = 1'b1;
                ctrl.rf_wr_sel = 2'd3;
                ctrl.alu_func  = {f7b5, f3};
                use_rs2        = 1'b1;
            end
            opc == OPC_SYSTEM: begin
                ctrl.valid     = 1'b1;
                ctrl.alu_func  = 4'd9;
                ctrl.rf_wr_sel = 2'd1;
                ctrl.reg_wr_en = (f3 != 3'd0);
                ctrl.csr_write = (f3 != 3'd0);
                is_trap        = (f3 == 3'd0);
            end
            default: begin
                use_rs1 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/otter_pipe_ctrl.sv
// OTTER 5-stage control: stage control words, hazards, forwarding, flush.
// Forwarding and write-through regfile assumed when OTTER_FWD_EN is defined.
module otter_pipe_ctrl
    import otter_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int RA_W         = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     dec_ir,
    input  logic            dec_valid,
    input  logic            br_eq,
    input  logic            br_lt,
    input  logic            br_ltu,
    input  logic            mem_ready,
    output logic            alu_srca,
    output logic [1:0]      alu_srcb,
    output logic [2:0]      pc_source,
    output logic            stall_pc,
    output logic            stall_dec,
    output logic            flush_dec,
    output logic [3:0]      ex_alu_func,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            ex_valid,
    output logic            mem_read,
    output logic            mem_write,
    output logic            mem_sign,
    output logic [1:0]      mem_size,
    output logic            mem_valid,
    output logic            wb_reg_wr_en,
    output logic            wb_csr_write,
    output logic [1:0]      wb_rf_wr_sel,
    output logic [RA_W-1:0] wb_wa,
    output logic            wb_valid
);

    ctrl_t      dc, dw, ex_q, mem_q, wb_q;
    logic       use_rs1, use_rs2, srca;
    logic [1:0] srcb;
    logic       is_jal, is_jalr, is_branch, is_trap;
    logic [1:0] fa, fb, ex_fa_q, ex_fb_q;
    logic [2:0] flush_cnt, xfer_sel;
    logic       dec_bub_q, dv, freeze, stall, taken;
    logic       r1_ex, r2_ex, r1_mem, r2_mem;

    logic [RA_W-1:0] rs1, rs2;

    otter_ctrl_decode u_dec (
        .ir        (dec_ir),
        .ctrl      (dc),
        .use_rs1   (use_rs1),
        .use_rs2   (use_rs2),
        .alu_srca  (srca),
        .alu_srcb  (srcb),
        .is_jal    (is_jal),
        .is_jalr   (is_jalr),
        .is_branch (is_branch),
        .is_trap   (is_trap)
    );

    function automatic logic hit(
        input logic [RA_W-1:0] rs,
        input logic            used,
        input ctrl_t           w
    );
        return used && (rs != '0) && w.valid && w.reg_wr_en
            && (w.rd[RA_W-1:0] == rs);
    endfunction

    // decode may hold a bubble loaded by a flush even if fetch says valid
    assign dv     = dec_valid & ~dec_bub_q & dc.valid;
    assign dw     = dv ? dc : CTRL_BUBBLE;
    assign rs1    = dec_ir[15 +: RA_W];
    assign rs2    = dec_ir[20 +: RA_W];
    assign r1_ex  = hit(rs1, use_rs1, ex_q);
    assign r2_ex  = hit(rs2, use_rs2, ex_q);
    assign r1_mem = hit(rs1, use_rs1, mem_q);
    assign r2_mem = hit(rs2, use_rs2, mem_q);

    assign freeze = mem_q.valid & (mem_q.mem_read | mem_q.mem_write)
                  & ~mem_ready;

`ifdef OTTER_FWD_EN
    logic load_use, ctl_haz;
    assign load_use = ex_q.mem_read & (r1_ex | r2_ex);
    assign ctl_haz  = (is_branch | is_jalr)
                    & (r1_ex | r2_ex | r1_mem | r2_mem);
    assign stall    = dv & (load_use | ctl_haz);

    always_comb begin
        fa = FWD_RF;
        fb = FWD_RF;
        if (dv) begin
            if (r1_ex)       fa = FWD_MEM;
            else if (r1_mem) fa = FWD_WB;
            if (r2_ex)       fb = FWD_MEM;
            else if (r2_mem) fb = FWD_WB;
        end
    end
`else
    logic r1_wb, r2_wb;
    assign r1_wb = hit(rs1, use_rs1, wb_q);
    assign r2_wb = hit(rs2, use_rs2, wb_q);
    assign stall = dv & (r1_ex | r2_ex | r1_mem | r2_mem | r1_wb | r2_wb);
    assign fa    = FWD_RF;
    assign fb    = FWD_RF;
`endif

    always_comb begin
        xfer_sel = PC_PLUS4;
        unique case (1'b1)
            is_jal:    xfer_sel = PC_JAL;
            is_jalr:   xfer_sel = PC_JALR;
            is_branch: xfer_sel = br_cond(dec_ir[14:12], br_eq, br_lt, br_ltu)
                                ? PC_BRANCH : PC_PLUS4;
            is_trap:   xfer_sel = PC_MTVEC;
            default:   xfer_sel = PC_PLUS4;
        endcase
    end

    assign taken     = dv & (xfer_sel != PC_PLUS4) & ~stall & ~freeze;
    assign pc_source = taken ? xfer_sel : PC_PLUS4;
    assign flush_dec = taken | (flush_cnt != 3'd0);
    assign stall_pc  = stall | freeze;
    assign stall_dec = stall | freeze;
    assign alu_srca  = dv & srca;
    assign alu_srcb  = dv ? srcb : 2'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q      <= CTRL_BUBBLE;
            mem_q     <= CTRL_BUBBLE;
            wb_q      <= CTRL_BUBBLE;
            ex_fa_q   <= FWD_RF;
            ex_fb_q   <= FWD_RF;
            flush_cnt <= 3'd0;
            dec_bub_q <= 1'b0;
        end else if (!freeze) begin
            ex_q    <= stall ? CTRL_BUBBLE : dw;
            ex_fa_q <= stall ? FWD_RF : fa;
            ex_fb_q <= stall ? FWD_RF : fb;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            if (taken)
                flush_cnt <= 3'(FLUSH_CYCLES - 1);
            else if (flush_cnt != 3'd0)
                flush_cnt <= flush_cnt - 3'd1;
            if (!stall)
                dec_bub_q <= flush_dec;
        end
    end

    assign ex_alu_func  = ex_q.valid ? ex_q.alu_func : 4'd0;
    assign fwd_a        = ex_fa_q;
    assign fwd_b        = ex_fb_q;
    assign ex_valid     = ex_q.valid;
    assign mem_read     = mem_q.valid & mem_q.mem_read;
    assign mem_write    = mem_q.valid & mem_q.mem_write;
    assign mem_sign     = mem_q.valid & mem_q.mem_sign;
    assign mem_size     = mem_q.valid ? mem_q.mem_size : 2'd0;
    assign mem_valid    = mem_q.valid;
    assign wb_reg_wr_en = wb_q.valid & wb_q.reg_wr_en & ~freeze;
    assign wb_csr_write = wb_q.valid & wb_q.csr_write & ~freeze;
    assign wb_rf_wr_sel = wb_q.valid ? wb_q.rf_wr_sel : 2'd0;
    assign wb_wa        = wb_q.valid ? wb_q.rd[RA_W-1:0] : '0;
    assign wb_valid     = wb_q.valid;

endmodule

// File: tb/tb_otter_pipe_ctrl.sv
// Directed bench for otter_pipe_ctrl (FLUSH_CYCLES = 2).
// Expected stall counts and forward selects follow OTTER_FWD_EN.
module tb_otter_pipe_ctrl;

`ifdef OTTER_FWD_EN
    localparam int         LU_STALLS   = 1;
    localparam int         RAW_STALLS  = 0;
    localparam int         JALR_STALLS = 2;
    localparam logic [1:0] LU_FWD_A    = 2'd2;
    localparam logic [1:0] RAW_FWD     = 2'd1;
`else
    localparam int         LU_STALLS   = 3;
    localparam int         RAW_STALLS  = 3;
    localparam int         JALR_STALLS = 3;
    localparam logic [1:0] LU_FWD_A    = 2'd0;
    localparam logic [1:0] RAW_FWD     = 2'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dec_ir = 32'h0;
    logic        dec_valid = 1'b0;
    logic        br_eq = 1'b0, br_lt = 1'b0, br_ltu = 1'b0;
    logic        mem_ready = 1'b1;
    logic        alu_srca;
    logic [1:0]  alu_srcb;
    logic [2:0]  pc_source;
    logic        stall_pc, stall_dec, flush_dec;
    logic [3:0]  ex_alu_func;
    logic [1:0]  fwd_a, fwd_b;
    logic        ex_valid;
    logic        mem_read, mem_write, mem_sign, mem_valid;
    logic [1:0]  mem_size;
    logic        wb_reg_wr_en, wb_csr_write, wb_valid;
    logic [1:0]  wb_rf_wr_sel;
    logic [4:0]  wb_wa;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    otter_pipe_ctrl #(.FLUSH_CYCLES(2), .RA_W(5)) dut (
        .clk(clk), .rst(rst), .dec_ir(dec_ir), .dec_valid(dec_valid),
        .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
        .mem_ready(mem_ready), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
        .pc_source(pc_source), .stall_pc(stall_pc), .stall_dec(stall_dec),
        .flush_dec(flush_dec), .ex_alu_func(ex_alu_func),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .ex_valid(ex_valid),
        .mem_read(mem_read), .mem_write(mem_write), .mem_sign(mem_sign),
        .mem_size(mem_size), .mem_valid(mem_valid),
        .wb_reg_wr_en(wb_reg_wr_en), .wb_csr_write(wb_csr_write),
        .wb_rf_wr_sel(wb_rf_wr_sel), .wb_wa(wb_wa), .wb_valid(wb_valid)
    );

    function automatic logic [31:0] i_addi(input logic [4:0] rd, rs1,
                                           input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] i_add(input logic [4:0] rd, rs1, rs2);
        return {7'h0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] i_lw(input logic [4:0] rd, rs1);
        return {12'h0, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] i_sw(input logic [4:0] rs2, rs1);
        return {7'h0, rs2, rs1, 3'b010, 5'h0, 7'b0100011};
    endfunction
    function automatic logic [31:0] i_beq(input logic [4:0] rs1, rs2);
        return {7'h0, rs2, rs1, 3'b000, 5'h0, 7'b1100011};
    endfunction
    function automatic logic [31:0] i_jalr(input logic [4:0] rd, rs1);
        return {12'h0, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ir);
        dec_ir    = ir;
        dec_valid = 1'b1;
    endtask

    task automatic idle();
        dec_ir    = 32'h0;
        dec_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        br_eq = 1'b0;
        mem_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        issue(i_addi(5'd9, 5'd0, 12'd1));
        tick();
        issue(i_lw(5'd5, 5'd1));
        tick();
        idle();
        tick();
        tests++;
        if (mem_read !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre_mem_read got %0b exp 1", mem_read);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({mem_read, mem_valid, ex_valid} !== 3'b000) begin
            fails++;
            $display("FAIL rst_async_mem got %b exp 000",
                     {mem_read, mem_valid, ex_valid});
        end
        tests++;
        if ({wb_reg_wr_en, wb_valid, wb_wa, wb_rf_wr_sel} !== 9'd0) begin
            fails++;
            $display("FAIL rst_async_wb got %h exp 0",
                     {wb_reg_wr_en, wb_valid, wb_wa, wb_rf_wr_sel});
        end
        #1 rst = 1'b0;
        issue(i_addi(5'd10, 5'd0, 12'd2));
        tick();
        idle();
        tests++;
        if (ex_valid !== 1'b1) begin
            fails++;
            $display("FAIL rst_first_ex got %0b exp 1", ex_valid);
        end
        tick();
        tests++;
        if (wb_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_wb_early got %0b exp 0", wb_valid);
        end
        tick();
        tests++;
        if ({wb_valid, wb_reg_wr_en, wb_wa} !== {2'b11, 5'd10}) begin
            fails++;
            $display("FAIL rst_wb_arrive got %h exp %h",
                     {wb_valid, wb_reg_wr_en, wb_wa}, {2'b11, 5'd10});
        end
    endtask

    task automatic test_load_use();
        int n;
        do_reset();
        issue(i_lw(5'd5, 5'd1));
        tick();
        issue(i_add(5'd6, 5'd5, 5'd1));
        #1;
        tests++;
        if ({stall_pc, stall_dec, pc_source} !== {2'b11, 3'd0}) begin
            fails++;
            $display("FAIL lu_stall got %b exp 11000",
                     {stall_pc, stall_dec, pc_source});
        end
        n = 0;
        while (stall_pc && n < 10) begin
            n++;
            tick();
            tests++;
            if (ex_valid !== 1'b0) begin
                fails++;
                $display("FAIL lu_bubble got %0b exp 0", ex_valid);
            end
        end
        tests++;
        if (n !== LU_STALLS) begin
            fails++;
            $display("FAIL lu_stall_cycles got %0d exp %0d", n, LU_STALLS);
        end
        tick();
        idle();
        tests++;
        if ({ex_valid, fwd_a, fwd_b, ex_alu_func} !==
            {1'b1, LU_FWD_A, 2'd0, 4'd0}) begin
            fails++;
            $display("FAIL lu_add_ex got %h exp %h",
                     {ex_valid, fwd_a, fwd_b, ex_alu_func},
                     {1'b1, LU_FWD_A, 2'd0, 4'd0});
        end
    endtask

    task automatic test_raw_alu();
        int n;
        do_reset();
        issue(i_addi(5'd5, 5'd0, 12'd3));
        tick();
        issue(i_add(5'd7, 5'd5, 5'd5));
        #1;
        n = 0;
        while (stall_pc && n < 10) begin
            n++;
            tick();
        end
        tests++;
        if (n !== RAW_STALLS) begin
            fails++;
            $display("FAIL raw_stall_cycles got %0d exp %0d", n, RAW_STALLS);
        end
        tick();
        idle();
        tests++;
        if ({ex_valid, fwd_a, fwd_b} !== {1'b1, RAW_FWD, RAW_FWD}) begin
            fails++;
            $display("FAIL raw_fwd got %h exp %h",
                     {ex_valid, fwd_a, fwd_b}, {1'b1, RAW_FWD, RAW_FWD});
        end
    endtask

    task automatic test_branch();
        do_reset();
        issue(i_beq(5'd1, 5'd2));
        br_eq = 1'b1;
        #1;
        tests++;
        if ({pc_source, flush_dec, stall_pc} !== {3'd2, 2'b10}) begin
            fails++;
            $display("FAIL br_taken got %b exp 01010",
                     {pc_source, flush_dec, stall_pc});
        end
        tick();
        tests++;
        if (ex_valid !== 1'b1) begin
            fails++;
            $display("FAIL br_xfer_ex got %0b exp 1", ex_valid);
        end
        issue(i_add(5'd11, 5'd1, 5'd2));
        #1;
        tests++;
        if ({pc_source, flush_dec} !== {3'd0, 1'b1}) begin
            fails++;
            $display("FAIL br_flush2 got %b exp 0001", {pc_source, flush_dec});
        end
        tick();
        tests++;
        if (ex_valid !== 1'b0) begin
            fails++;
            $display("FAIL br_wrong1_ex got %0b exp 0", ex_valid);
        end
        issue(i_add(5'd12, 5'd1, 5'd2));
        #1;
        tests++;
        if (flush_dec !== 1'b0) begin
            fails++;
            $display("FAIL br_flush_end got %0b exp 0", flush_dec);
        end
        tick();
        tests++;
        if (ex_valid !== 1'b0) begin
            fails++;
            $display("FAIL br_wrong2_ex got %0b exp 0", ex_valid);
        end
        issue(i_addi(5'd13, 5'd0, 12'd1));
        tick();
        tests++;
        if (ex_valid !== 1'b1) begin
            fails++;
            $display("FAIL br_target_ex got %0b exp 1", ex_valid);
        end
        br_eq = 1'b0;
        issue(i_beq(5'd1, 5'd2));
        #1;
        tests++;
        if ({pc_source, flush_dec} !== 4'd0) begin
            fails++;
            $display("FAIL br_not_taken got %b exp 0000",
                     {pc_source, flush_dec});
        end
        tick();
        issue(i_addi(5'd14, 5'd0, 12'd1));
        #1;
        tests++;
        if ({ex_valid, flush_dec} !== 2'b10) begin
            fails++;
            $display("FAIL br_nt_flow got %b exp 10", {ex_valid, flush_dec});
        end
        tick();
        idle();
        tests++;
        if (ex_valid !== 1'b1) begin
            fails++;
            $display("FAIL br_nt_next_ex got %0b exp 1", ex_valid);
        end
    endtask

    task automatic test_jalr_hazard();
        int n;
        do_reset();
        issue(i_addi(5'd3, 5'd0, 12'd4));
        tick();
        issue(i_jalr(5'd0, 5'd3));
        #1;
        tests++;
        if ({stall_pc, pc_source, flush_dec} !== {1'b1, 3'd0, 1'b0}) begin
            fails++;
            $display("FAIL jalr_stall got %b exp 10000",
                     {stall_pc, pc_source, flush_dec});
        end
        n = 0;
        while (stall_pc && n < 10) begin
            n++;
            tick();
        end
        tests++;
        if (n !== JALR_STALLS) begin
            fails++;
            $display("FAIL jalr_stall_cycles got %0d exp %0d", n, JALR_STALLS);
        end
        tests++;
        if ({pc_source, flush_dec} !== {3'd3, 1'b1}) begin
            fails++;
            $display("FAIL jalr_taken got %b exp 0111", {pc_source, flush_dec});
        end
        idle();
    endtask

    task automatic test_freeze();
        do_reset();
        issue(i_addi(5'd9, 5'd0, 12'd1));
        tick();
        issue(i_sw(5'd2, 5'd1));
        tick();
        idle();
        tick();
        mem_ready = 1'b0;
        issue(i_addi(5'd15, 5'd0, 12'd7));
        #1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({wb_reg_wr_en, wb_valid, wb_wa} !== {2'b01, 5'd9}) begin
                fails++;
                $display("FAIL frz_wb[%0d] got %h exp %h", i,
                         {wb_reg_wr_en, wb_valid, wb_wa}, {2'b01, 5'd9});
            end
            tests++;
            if ({mem_write, mem_valid, stall_pc, ex_valid} !== 4'b1110) begin
                fails++;
                $display("FAIL frz_hold[%0d] got %b exp 1110", i,
                         {mem_write, mem_valid, stall_pc, ex_valid});
            end
            tick();
        end
        mem_ready = 1'b1;
        #1;
        tests++;
        if ({wb_reg_wr_en, stall_pc} !== 2'b10) begin
            fails++;
            $display("FAIL frz_release got %b exp 10",
                     {wb_reg_wr_en, stall_pc});
        end
        tick();
        idle();
        tests++;
        if ({wb_reg_wr_en, wb_valid, ex_valid} !== 3'b011) begin
            fails++;
            $display("FAIL frz_after got %b exp 011",
                     {wb_reg_wr_en, wb_valid, ex_valid});
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_raw_alu();
        test_branch();
        test_jalr_hazard();
        test_freeze();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/otter_pipe_ctrl.md
# otter_pipe_ctrl

Pipelined control unit for the 5-stage OTTER core. It decodes the decode-stage instruction once into a control word and carries that word through EX, MEM and WB registers, so the later stages no longer re-decode their IR. It also detects hazards and generates stall, flush and forwarding controls. Branch and jump resolution stays in decode, and the branch-penalty depth is parametrised.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 1: cycles of decode bubbles after a taken transfer. Range 1..7.
- `RA_W`, default 5: register-address width. Use 4 for RV32E.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `dec_ir` in 32: instruction in decode.
- `dec_valid` in 1: decode holds a real instruction.
- `br_eq`, `br_lt`, `br_ltu` in 1: comparator flags for the decode-stage operands.
- `mem_ready` in 1: data memory completes its access this cycle.
- `alu_srca` out 1, `alu_srcb` out 2, `pc_source` out 3: decode-stage controls, combinational.
- `stall_pc`, `stall_dec` out 1: hold the PC and the decode IR.
- `flush_dec` out 1: decode IR loads a bubble at the next edge.
- `ex_alu_func` out 4, `fwd_a` out 2, `fwd_b` out 2, `ex_valid` out 1: EX controls.
  - `fwd` codes: 0 = regfile, 1 = MEM ALU result, 2 = WB data.
- `mem_read`, `mem_write`, `mem_sign` out 1, `mem_size` out 2, `mem_valid` out 1: MEM controls.
- `wb_reg_wr_en`, `wb_csr_write` out 1, `wb_rf_wr_sel` out 2, `wb_wa` out `RA_W`, `wb_valid` out 1: WB controls.

## Operation
- **Control word** `ctrl_t` fields: alu_func, mem_read, mem_write, mem_sign, mem_size, reg_wr_en, csr_write, rf_wr_sel, rd, valid.
  - Encodings are the existing OTTER encodings: LUI/JAL/JALR/SYSTEM give alu_func 9; SRAI/SRA use func7[5].
  - A bubble is an all-zero word.
  - Outputs are the stage word gated by its valid bit.
- **Source usage**:
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used by BRANCH, STORE and OP.
  - x0 never causes a hazard and is never forwarded.
- **freeze** = mem_valid & (mem_read|mem_write) & ~mem_ready.
  - PC, DEC, EX, MEM and WB registers all hold.
  - wb_reg_wr_en and wb_csr_write are forced to 0.
- **Load-use**: EX holds a valid LOAD whose rd matches a used rs of the decode instruction.
  - Stall one cycle: stall_pc = stall_dec = 1, and EX loads a bubble.
- **Branch/JALR operand hazard**: a decode BRANCH or JALR whose used rs matches rd of a valid reg-writer in EX or in MEM stalls, with EX loading a bubble.
- **Forwarding**: computed in decode and registered into EX with the word.
  - fwd = 1 if the EX-stage writer's rd matches; else fwd = 2 if the MEM-stage writer's rd matches; else fwd = 0.
  - MEM has priority over WB.
- **Taken transfer**:
  - Sources: a JAL, a JALR, or a BRANCH whose condition holds per func3.
  - Applies only when dec_valid = 1 and there is no stall or freeze.
  - pc_source is set to 1, 3 or 2 respectively; SYSTEM with func3 = 0 gives 5.
  - flush_dec = 1 on that cycle, and flush_cnt loads `FLUSH_CYCLES`-1.
  - While flush_cnt != 0, flush_dec = 1 and the counter decrements.
  - The transfer instruction itself advances to EX.
- When stalled or frozen, pc_source is forced to 0.
- **Simultaneous events**:
  - Freeze dominates stall; stall dominates taken.
  - A taken transfer during an active flush cannot occur, because decode holds a bubble.
- **Reset**:
  - All stage words clear, all valid bits clear, and flush_cnt is 0.
  - Every registered output reads 0 immediately.
  - Mid-operation reset discards all in-flight instructions.

## Timing
- Decode outputs and stall/flush outputs are combinational from dec_ir, the flags and the stage registers, in the same cycle.
- EX, MEM and WB outputs are registered: a word appears in EX 1, MEM 2 and WB 3 edges after leaving decode, absent stalls.
- Load-use costs 1 bubble; a taken transfer costs `FLUSH_CYCLES` bubbles; a freeze costs 1 cycle per cycle with mem_ready low.
- The WB instruction writes exactly once, on the cycle the freeze releases.

## Configuration
- **`OTTER_FWD_EN` defined**: forwarding as above; only load-use and branch/JALR operand hazards stall.
- **`OTTER_FWD_EN` undefined**:
  - fwd_a and fwd_b are tied to 0.
  - Decode stalls while any used rs matches rd of a valid reg-writer in EX, MEM or WB.
  - The regfile is not write-through.

## Structure
- **Package `otter_ctrl_pkg`**: opcode_t, func3 branch enum, ctrl_t, fwd-select constants, bubble constant.
- **Sub-module `otter_ctrl_decode`**: purely combinational, dec_ir to ctrl_t plus rs-usage bits.
- **Top level `otter_pipe_ctrl`**: the stage registers, hazard logic and flush counter.

## Test plan
- Reset asserted between edges while a LOAD is in MEM → mem_read, mem_valid and all WB outputs go to 0 without a clock edge; first instruction after release reaches WB 3 edges later.
- `lw x5`, `add x6,x5,x1` → stall_pc = stall_dec = 1 for exactly 1 cycle, EX bubble, then the add enters EX with fwd_a = 2, fwd_b = 0.
- `addi x5,x0,3`, `add x7,x5,x5` → no stall; add in EX with fwd_a = fwd_b = 1.
- `FLUSH_CYCLES` = 2, `beq` with br_eq = 1 → pc_source = 2 for 1 cycle; flush_dec high 2 cycles; the 2 following fetched words never reach EX. With br_eq = 0 → pc_source = 0 and no flush.
- `sw` in MEM, mem_ready low 3 cycles, `addi x9` in WB → all stages hold 3 cycles, wb_reg_wr_en = 0 throughout, then 1 for exactly one cycle.
- `OTTER_FWD_EN` undefined: `addi x5`, `add x6,x5,x2` → stall 3 cycles, then the add enters EX with fwd_a = 0.
